// File: rtl/arbiter_request_fifo.sv
// Staging FIFO in front of one round-robin arbiter input; request excludes the grant being served.
// Define ARB_FIFO_STATS_EN to add push/pop counters and an occupancy high-water mark.
module arbiter_request_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       enabled,
    input  logic                       push,
    input  logic [0:WIDTH-1]           data_in,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       request,
    input  logic                       ready,
    output logic [0:WIDTH-1]           buffer_out,
    output logic                       overflow_error,
    output logic                       underflow_error
`ifdef ARB_FIFO_STATS_EN
    ,
    output logic [31:0]                push_count,
    output logic [31:0]                pop_count,
    output logic [$clog2(DEPTH):0]     max_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [0:WIDTH-1] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_ok, pop_ok, is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign push_ok  = push & ~is_full;
    // ready only pops while the port is enabled; a disabled port ignores it entirely.
    assign pop_ok   = enabled & ready & ~is_empty;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push & is_full);
        unf_d    = unf_q | (enabled & ready & is_empty);
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale contents never leak.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_in;
    end

    assign count           = count_q;
    assign empty           = is_empty;
    assign full            = is_full;
    assign almost_full     = (count_q >= CW'(ALMOST_FULL));
    // Subtract the grant in service so the registered-grant arbiter never grants an empty FIFO.
    assign request         = enabled & (count_q > CW'(ready));
    assign buffer_out      = is_empty ? '0 : mem_q[rd_ptr_q];
    assign overflow_error  = ovf_q;
    assign underflow_error = unf_q;

`ifdef ARB_FIFO_STATS_EN
    logic [31:0]   push_count_q, pop_count_q;
    logic [CW-1:0] max_count_q, max_count_d;

    assign max_count_d = (count_d > max_count_q) ? count_d : max_count_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            push_count_q <= '0;
            pop_count_q  <= '0;
            max_count_q  <= '0;
        end else begin
            push_count_q <= push_count_q + 32'(push_ok);
            pop_count_q  <= pop_count_q + 32'(pop_ok);
            max_count_q  <= max_count_d;
        end
    end

    assign push_count = push_count_q;
    assign pop_count  = pop_count_q;
    assign max_count  = max_count_q;
`endif

endmodule

// File: tb/tb_arbiter_request_fifo.sv
// Bench for arbiter_request_fifo: vector table plus a queue model that scores every pop.
// Stats checks are included when ARB_FIFO_STATS_EN is defined.
module tb_arbiter_request_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int CW    = 5;

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             enabled = 1'b0;
    logic             push = 1'b0;
    logic             ready = 1'b0;
    logic [0:WIDTH-1] data_in = '0;
    logic [0:WIDTH-1] buffer_out;
    logic             full, almost_full, empty, request;
    logic             overflow_error, underflow_error;
    logic [CW-1:0]    count;
`ifdef ARB_FIFO_STATS_EN
    logic [31:0]      push_count, pop_count;
    logic [CW-1:0]    max_count;
`endif

    arbiter_request_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
        .clock           (clock),
        .rst             (rst),
        .enabled         (enabled),
        .push            (push),
        .data_in         (data_in),
        .full            (full),
        .almost_full     (almost_full),
        .empty           (empty),
        .count           (count),
        .request         (request),
        .ready           (ready),
        .buffer_out      (buffer_out),
        .overflow_error  (overflow_error),
        .underflow_error (underflow_error)
`ifdef ARB_FIFO_STATS_EN
        ,
        .push_count      (push_count),
        .pop_count       (pop_count),
        .max_count       (max_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mq [$];
    bit          m_ovf, m_unf;
    int unsigned m_push, m_pop, m_max;

    typedef struct {
        bit         push;
        logic [7:0] data;
        bit         ready;
        bit         en;
        int         exp_count;
        bit         exp_req;
        bit         exp_empty;
        logic [7:0] exp_bout;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after a rising edge; outputs are then sampled well before the next one.
    task automatic apply(input bit p, input logic [7:0] d, input bit r, input bit en);
        push    = p;
        data_in = d;
        ready   = r;
        enabled = en;
        #3;
    endtask

    task automatic model_check();
        int sz = mq.size();
        check("count", count, sz);
        check("empty", empty, sz == 0);
        check("full", full, sz == DEPTH);
        check("almost_full", almost_full, sz >= AF);
        check("request", request, enabled && (sz > int'(ready)));
        if (sz == 0) check("buffer_out_empty", buffer_out, 0);
        check("overflow_error", overflow_error, m_ovf);
        check("underflow_error", underflow_error, m_unf);
`ifdef ARB_FIFO_STATS_EN
        check("push_count", push_count, m_push);
        check("pop_count", pop_count, m_pop);
        check("max_count", max_count, m_max);
`endif
    endtask

    // Update the model for the current inputs, scoring the head on every pop, then clock.
    task automatic advance();
        int sz      = mq.size();
        bit pop_ok  = enabled && ready && (sz > 0);
        bit push_ok = push && (sz < DEPTH);
        if (push && sz == DEPTH) m_ovf = 1'b1;
        if (enabled && ready && sz == 0) m_unf = 1'b1;
        if (pop_ok) begin
            check("pop_data", buffer_out, mq[0]);
            void'(mq.pop_front());
            m_pop++;
        end
        if (push_ok) begin
            mq.push_back(data_in);
            m_push++;
        end
        if (mq.size() > m_max) m_max = mq.size();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input bit p, input logic [7:0] d, input bit r, input bit en);
        apply(p, d, r, en);
        model_check();
        advance();
    endtask

    // Asserts reset asynchronously wherever the bench currently is, checks at once, releases after an edge.
    task automatic do_reset();
        rst     = 1'b1;
        push    = 1'b0;
        ready   = 1'b0;
        enabled = 1'b1;
        data_in = '0;
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_request", request, 0);
        check("rst_buffer_out", buffer_out, 0);
        check("rst_overflow", overflow_error, 0);
        check("rst_underflow", underflow_error, 0);
`ifdef ARB_FIFO_STATS_EN
        check("rst_push_count", push_count, 0);
        check("rst_pop_count", pop_count, 0);
        check("rst_max_count", max_count, 0);
`endif
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_push = 0;
        m_pop  = 0;
        m_max  = 0;
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b0, 1'b0, 8'hA5};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{1'b1, 8'h3C, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h00};
        vecs[5] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1, 1'b0, 1'b0, 8'h3C};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b0, 8'h5A};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b0, 1'b0, 8'h5A};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h00};

        #2;
        do_reset();

        // Single push, same-cycle request drop, push+pop at count 1.
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].push, vecs[i].data, vecs[i].ready, vecs[i].en);
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            check($sformatf("vec%0d_request", i), request, vecs[i].exp_req);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
            check($sformatf("vec%0d_buffer_out", i), buffer_out, vecs[i].exp_bout);
            advance();
        end

        // Fill to full, overflow alone and together with a pop, then drain across the wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 1'b0, 1'b1);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Steady push+pop at count 5.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Underflow on an empty FIFO.
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("underflow_sticky", underflow_error, 1);

        // Disabled port: no request, ready ignored.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("disabled_count_kept", count, 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1);

        // Reset in the middle of a drain at count 7.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        apply(1'b0, 8'h00, 1'b1, 1'b1);
        check("pre_reset_count", count, 7);
        do_reset();
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef ARB_FIFO_STATS_EN
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("stats_push_10", push_count, 10);
        check("stats_pop_4", pop_count, 4);
        check("stats_max_10", max_count, 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
